// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall sequencer: MDU latencies, countdown width, $0 index.
package stall_ctrl_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned REG_W           = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Register match that never fires on $0, which is hardwired and never a real dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// MDU occupancy countdown: loads on a start pulse when idle, decrements to zero,
// flags a sticky overlap error when a start arrives while still busy.
module mdu_busy_timer
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic mdu_start,
  input  logic mdu_is_div,
  output logic mdu_busy,
  output logic err_overlap
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load_val;
  logic             r_err;
  logic             w_err_nxt;

  assign w_load_val = mdu_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // A start while busy is dropped; the running countdown is left untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (mdu_start) begin
          w_cnt_nxt   = w_load_val;
          w_state_nxt = (w_load_val != '0) ? ST_BUSY : ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mdu_start) begin
          w_err_nxt = 1'b1;
        end
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign mdu_busy    = (r_cnt != '0);
  assign err_overlap = r_err;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-end stall/bubble sequencer: load-use and MDU-occupancy hazards drive PC/IFID
// enables and the ID/EX bubble. HAZARD_STALL_PERF_EN adds saturating stall counters.
module hazard_stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_tuse0,
  input  logic       id_rt_tuse0,
  input  logic       id_rs_tuse1,
  input  logic       id_rt_tuse1,
  input  logic       id_is_md,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       mem_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mdu_start,
  input  logic       mdu_is_div,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_bubble,
  output logic       mdu_busy,
  output logic       stall,
  output logic       err_overlap
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] mdu_stall_cycles
`endif
);

  logic w_ex_hz;
  logic w_mem_hz;
  logic w_mdu_hz;
  logic w_mdu_busy;
  logic w_stall;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_mdu_busy_timer (
    .clk         (clk),
    .reset       (reset),
    .mdu_start   (mdu_start),
    .mdu_is_div  (mdu_is_div),
    .mdu_busy    (w_mdu_busy),
    .err_overlap (err_overlap)
  );

  // EX load result is late for any consumer; MEM load result is late only for ID-stage consumers.
  assign w_ex_hz  = ex_is_load &
                    (((id_rs_tuse0 | id_rs_tuse1) & reg_match(id_rs, ex_rd)) |
                     ((id_rt_tuse0 | id_rt_tuse1) & reg_match(id_rt, ex_rd)));
  assign w_mem_hz = mem_is_load &
                    ((id_rs_tuse0 & reg_match(id_rs, mem_rd)) |
                     (id_rt_tuse0 & reg_match(id_rt, mem_rd)));
  assign w_mdu_hz = id_is_md & (w_mdu_busy | mdu_start);
  assign w_stall  = w_ex_hz | w_mem_hz | w_mdu_hz;

  assign stall        = w_stall;
  assign pc_en        = ~w_stall;
  assign if_id_en     = ~w_stall;
  assign id_ex_bubble = w_stall;
  assign mdu_busy     = w_mdu_busy;

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_mdu_stall_cycles;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles     <= '0;
      r_mdu_stall_cycles <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_mdu_hz && (r_mdu_stall_cycles != '1)) begin
        r_mdu_stall_cycles <= r_mdu_stall_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles     = r_stall_cycles;
  assign mdu_stall_cycles = r_mdu_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a behavioural reference model.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_rs_tuse0, id_rt_tuse0, id_rs_tuse1, id_rt_tuse1;
  logic       id_is_md, ex_is_load, mem_is_load, mdu_start, mdu_is_div;
  logic       pc_en, if_id_en, id_ex_bubble, mdu_busy, stall, err_overlap;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles, mdu_stall_cycles;
`endif

  int n_cmp;
  int n_mis;

  // Reference model state: remaining busy cycles, sticky error, perf totals.
  int      m_busy_left;
  bit      m_err;
  longint  m_stall_tot;
  longint  m_mdu_tot;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_tuse0  (id_rs_tuse0),
    .id_rt_tuse0  (id_rt_tuse0),
    .id_rs_tuse1  (id_rs_tuse1),
    .id_rt_tuse1  (id_rt_tuse1),
    .id_is_md     (id_is_md),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .mem_is_load  (mem_is_load),
    .mem_rd       (mem_rd),
    .mdu_start    (mdu_start),
    .mdu_is_div   (mdu_is_div),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_bubble (id_ex_bubble),
    .mdu_busy     (mdu_busy),
    .stall        (stall),
    .err_overlap  (err_overlap)
`ifdef HAZARD_STALL_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .mdu_stall_cycles (mdu_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    id_rs_tuse0 = 1'b0; id_rt_tuse0 = 1'b0; id_rs_tuse1 = 1'b0; id_rt_tuse1 = 1'b0;
    id_is_md = 1'b0; ex_is_load = 1'b0; mem_is_load = 1'b0;
    mdu_start = 1'b0; mdu_is_div = 1'b0;
  endtask

  function automatic bit model_stall(output bit mdu_cond);
    bit ex_c, mem_c;
    ex_c = ex_is_load &&
           (((id_rs_tuse0 || id_rs_tuse1) && id_rs != 0 && id_rs == ex_rd) ||
            ((id_rt_tuse0 || id_rt_tuse1) && id_rt != 0 && id_rt == ex_rd));
    mem_c = mem_is_load &&
            ((id_rs_tuse0 && id_rs != 0 && id_rs == mem_rd) ||
             (id_rt_tuse0 && id_rt != 0 && id_rt == mem_rd));
    mdu_cond = id_is_md && (m_busy_left > 0 || mdu_start);
    return ex_c || mem_c || mdu_cond;
  endfunction

  // Check outputs mid-cycle, then advance the model across the coming rising edge.
  task automatic step(input bit full_check);
    bit st, mc;
    @(negedge clk);
    st = model_stall(mc);
    check_val("stall", 32'(stall), 32'(st));
    check_val("mdu_busy", 32'(mdu_busy), 32'(m_busy_left > 0));
    check_val("err_overlap", 32'(err_overlap), 32'(m_err));
    if (full_check) begin
      check_val("pc_en", 32'(pc_en), 32'(!st));
      check_val("if_id_en", 32'(if_id_en), 32'(!st));
      check_val("id_ex_bubble", 32'(id_ex_bubble), 32'(st));
    end
`ifdef HAZARD_STALL_PERF_EN
    check_val("stall_cycles", stall_cycles, 32'(m_stall_tot));
    check_val("mdu_stall_cycles", mdu_stall_cycles, 32'(m_mdu_tot));
`endif
    if (!reset) begin
      m_busy_left = 0; m_err = 1'b0; m_stall_tot = 0; m_mdu_tot = 0;
    end else begin
      if (st) m_stall_tot++;
      if (mc) m_mdu_tot++;
      if (mdu_start && m_busy_left == 0) begin
        m_busy_left = mdu_is_div ? 10 : 5;
      end else begin
        if (mdu_start) m_err = 1'b1;
        if (m_busy_left > 0) m_busy_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_busy_left = 0; m_err = 1'b0; m_stall_tot = 0; m_mdu_tot = 0;
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m_busy_left = 0; m_err = 1'b0; m_stall_tot = 0; m_mdu_tot = 0;

    // Reset then idle, with literal expectations.
    @(negedge clk);
    check_val("rst_pc_en", 32'(pc_en), 32'd1);
    check_val("rst_if_id_en", 32'(if_id_en), 32'd1);
    check_val("rst_bubble", 32'(id_ex_bubble), 32'd0);
    check_val("rst_mdu_busy", 32'(mdu_busy), 32'd0);
    check_val("rst_err", 32'(err_overlap), 32'd0);
    @(posedge clk); #1;

    // EX load-use, then $0 exclusion.
    ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_tuse1 = 1'b1;
    #1 check_val("ex_lu_stall", 32'(stall), 32'd1);
    step(1'b1);
    ex_rd = 5'd0; id_rs = 5'd0;
    #1 check_val("ex_lu_zero", 32'(stall), 32'd0);
    step(1'b1);
    idle_inputs();

    // MEM load feeding a branch compare, then an EX-stage consumer.
    mem_is_load = 1'b1; mem_rd = 5'd9; id_rt = 5'd9; id_rt_tuse0 = 1'b1;
    #1 check_val("mem_br_stall", 32'(stall), 32'd1);
    step(1'b1);
    id_rt_tuse0 = 1'b0; id_rt_tuse1 = 1'b1;
    #1 check_val("mem_ex_use", 32'(stall), 32'd0);
    step(1'b1);
    idle_inputs();

    // Third load-use stall (rt vs EX), then mult followed by mflo held in ID.
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_rt_tuse0 = 1'b1;
    step(1'b1);
    idle_inputs();
    id_is_md = 1'b1; mdu_start = 1'b1; mdu_is_div = 1'b0;
    step(1'b1);
    mdu_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("mult_busy", 32'(mdu_busy), 32'd1);
      step(1'b1);
    end
    check_val("mult_done_busy", 32'(mdu_busy), 32'd0);
    check_val("mult_done_stall", 32'(stall), 32'd0);
`ifdef HAZARD_STALL_PERF_EN
    check_val("perf_stall_total", stall_cycles, 32'd9);
    check_val("perf_mdu_total", mdu_stall_cycles, 32'd6);
`endif
    step(1'b1);
    idle_inputs();

    // Div, overlapping start at cycle 3, reset at cycle 6.
    mdu_start = 1'b1; mdu_is_div = 1'b1;
    step(1'b1);
    mdu_start = 1'b0;
    step(1'b1);
    step(1'b1);
    mdu_start = 1'b1; mdu_is_div = 1'b0;
    step(1'b1);
    mdu_start = 1'b0;
    check_val("ovl_err", 32'(err_overlap), 32'd1);
    step(1'b1);
    step(1'b1);
    reset = 1'b0; mdu_start = 1'b1;
    step(1'b1);
    reset = 1'b1; mdu_start = 1'b0;
    check_val("rst_abort_busy", 32'(mdu_busy), 32'd0);
    check_val("rst_abort_err", 32'(err_overlap), 32'd0);
    step(1'b1);

    // Overlap alone must not stretch the countdown past ten busy cycles.
    mdu_start = 1'b1; mdu_is_div = 1'b1;
    step(1'b1);
    mdu_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      mdu_start = (i == 3);
      check_val("div_busy", 32'(mdu_busy), 32'd1);
      step(1'b1);
    end
    mdu_start = 1'b0;
    check_val("div_end_busy", 32'(mdu_busy), 32'd0);
    check_val("div_end_err", 32'(err_overlap), 32'd1);
    step(1'b1);

    // Randomized traffic over a small register range so matches are frequent.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      id_rs_tuse0 = 1'($urandom_range(0, 1));
      id_rt_tuse0 = 1'($urandom_range(0, 1));
      id_rs_tuse1 = 1'($urandom_range(0, 1));
      id_rt_tuse1 = 1'($urandom_range(0, 1));
      id_is_md    = ($urandom_range(0, 2) == 0);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      mem_is_load = ($urandom_range(0, 2) == 0);
      mdu_start   = ($urandom_range(0, 7) == 0);
      mdu_is_div  = 1'($urandom_range(0, 1));
      step(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/bubble sequencer for the 5-stage pipeline.
- Detects load-use hazards and multiply/divide-unit (MDU) occupancy.
- Drives the enable of PC and IF/ID, and the bubble reset of ID/EX.
- EX/MEM and MEM/WB always advance; this block only freezes the front end and injects a bubble into EX.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the busy countdown; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rs_tuse0  in  1  ID instruction needs rs in ID (branch/jr).
- id_rt_tuse0  in  1  ID instruction needs rt in ID (branch).
- id_rs_tuse1  in  1  ID instruction needs rs in EX.
- id_rt_tuse1  in  1  ID instruction needs rt in EX.
- id_is_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- ex_is_load  in  1  EX holds a load.
- ex_rd  in  5  EX destination register.
- mem_is_load  in  1  MEM holds a load.
- mem_rd  in  5  MEM destination register.
- mdu_start  in  1  one-cycle pulse: MDU op starts in EX this cycle.
- mdu_is_div  in  1  qualifies mdu_start: 1 = div, 0 = mult.
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_bubble  out  1  clears ID/EX to a nop on this edge.
- mdu_busy  out  1  MDU countdown non-zero.
- stall  out  1  aggregate stall indicator.
- err_overlap  out  1  sticky: mdu_start seen while busy.

Behaviour:
- Hazard rules (all register matches exclude $0):
  - Load-use, EX: stall when ex_is_load and ((id_rs_tuse0|id_rs_tuse1) and id_rs==ex_rd, or (id_rt_tuse0|id_rt_tuse1) and id_rt==ex_rd).
  - Load-use, MEM: stall when mem_is_load and (id_rs_tuse0 and id_rs==mem_rd, or id_rt_tuse0 and id_rt==mem_rd).
  - MDU: stall when id_is_md and (mdu_busy or mdu_start).
- stall = OR of the three conditions; combinational from inputs and registered state, zero-cycle latency.
- When stall=1: pc_en=0, if_id_en=0, id_ex_bubble=1. When stall=0: pc_en=1, if_id_en=1, id_ex_bubble=0.
- Several conditions true at once still produce a single stall cycle per clock; no stall accumulation.
- Countdown cnt (CNT_W bits):
  - mdu_start with cnt==0 loads MULT_CYCLES or DIV_CYCLES (per mdu_is_div) at the edge.
  - Otherwise cnt decrements at each edge while non-zero; it never wraps below 0.
  - mdu_busy = (cnt!=0), so it is high for exactly N cycles after the start edge.
- An ID md instruction issues in the first cycle where cnt==0 and mdu_start==0.
- mdu_start while cnt!=0: the load is ignored (countdown continues unchanged) and err_overlap is set; err_overlap clears only on reset.
- State FSM:
  - IDLE (cnt==0) --start--> BUSY.
  - BUSY --cnt==1--> IDLE.
  - BUSY --start--> BUSY, with err_overlap set.
- Reset (reset==0 at an edge): cnt=0, err_overlap=0. After reset, with idle inputs: mdu_busy=0, stall=0, pc_en=1, if_id_en=1, id_ex_bubble=0.
- Reset mid-countdown aborts it immediately; the next cycle is IDLE.
- reset has priority over mdu_start.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and mdu_stall_cycles[31:0].
  - stall_cycles increments on every edge where stall=1.
  - mdu_stall_cycles increments only when the MDU condition holds.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header stall_ctrl_pkg holds:
  - MULT_CYCLES and DIV_CYCLES defaults.
  - REG_ZERO = 5'd0.
  - The countdown width constant.
- One natural sub-module: mdu_busy_timer. It contains the countdown, the load/decrement logic, mdu_busy and err_overlap.
- Hazard comparators and output muxing stay in the top level.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with all inputs 0 -> pc_en=1, if_id_en=1, id_ex_bubble=0, mdu_busy=0, err_overlap=0.
- EX load-use: ex_is_load=1, ex_rd=8, id_rs=8, id_rs_tuse1=1 -> stall=1 for that cycle. With ex_rd=0 instead -> stall=0.
- MEM branch hazard: mem_is_load=1, mem_rd=9, id_rt=9, id_rt_tuse0=1 -> stall=1. Same with id_rt_tuse0=0, id_rt_tuse1=1 -> stall=0.
- Mult then mflo: mdu_start=1, mdu_is_div=0 with id_is_md=1 held -> stall=1 on the start cycle plus 5 busy cycles. mdu_busy drops after exactly 5 edges; stall=0 on the 7th cycle.
- Overlap and reset: div start (10 cycles), second start at cycle 3 -> err_overlap=1 and busy still ends at cycle 10. reset=0 at cycle 6 -> mdu_busy=0 and err_overlap=0 next cycle.
- Perf (HAZARD_STALL_PERF_EN): 3 load-use stalls plus one mult/mfhi sequence (6 stall cycles) -> stall_cycles=9, mdu_stall_cycles=6.
